naxi_slave_mem_model: RTL and testbench

- Behavioural-synthesizable NAXI slave memory that terminates the cache's master-side NAXI port (the m_creq/m_dreq/m_rreq bundle) in the 1xm1xs cache bench.
- Accepts read and write commands, absorbs write data into a backing array, and returns read bursts after a programmable latency.
- Stalls are driven from internal FIFO occupancy.

---
 rtl/naxi_slv_pkg.sv | 30 +++
 rtl/naxi_slv_fifo.sv | 68 ++++++
 rtl/naxi_slave_mem_model.sv | 234 +++++++++++++++++++++++
 tb/tb_naxi_slave_mem_model.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/naxi_slv_pkg.sv
// Shared definitions for the NAXI slave memory model.
//   - command type encodings carried on m_creq_type
//   - attribute bit position of the "last beat" flag on m_rreq_attr
//   - read engine state encoding
//   - queued command record (id, burst size, starting array index)
// The record field widths match the default NXIDWIDTH / NXSIZEWIDTH / BITMEM
// of naxi_slave_mem_model; keep them in step if those defaults change.
package naxi_slv_pkg;

    localparam int NX_TYPE_RD   = 0;
    localparam int NX_TYPE_WR   = 1;
    localparam int NX_ATTR_LAST = 0;

    localparam int NX_ID_W   = 4;
    localparam int NX_SIZE_W = 8;
    localparam int NX_IDX_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } rd_state_e;

    typedef struct packed {
        logic [NX_ID_W-1:0]   id;
        logic [NX_SIZE_W-1:0] size;
        logic [NX_IDX_W-1:0]  index;
    } nx_cmd_t;

endpackage

// File: rtl/naxi_slv_fifo.sv
// Synchronous command FIFO used for the read and write command queues.
// Ports:
//   clk, rst     clock, synchronous active-low reset (pointers/count only)
//   push_i       write push_data_i when not full
//   pop_i        drop the head entry when not empty
//   head_o       current head entry (valid while !empty_o)
//   full_o       occupancy == DEPTH
//   empty_o      occupancy == 0
// full_o / empty_o depend only on the registered count, so a push on a full
// FIFO is refused even when a pop happens in the same cycle.
module naxi_slv_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = store_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/naxi_slave_mem_model.sv
// NAXI slave memory terminating the cache master-side port (m_creq/m_dreq/m_rreq).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   m_creq_*                 command in; rdstall/wrstall out = queue full
//   m_dreq_*                 write beats in; m_dreq_stall out = no write command queued
//   m_rreq_*                 read beats out (attr bit0 = last), m_rreq_stall in
//   err                      sticky: illegal command type or write-data id mismatch
// Reads launch only when the write queue is empty, so every queued write has
// landed in the array before a read samples it. First beat appears RDLAT
// cycles after launch. The array itself is never reset.
// Build option NAXI_SLV_RANDSTALL_EN: a 16-bit LFSR injects extra stalls on
// rdstall/wrstall/dreq_stall and one extra latency cycle per burst.
module naxi_slave_mem_model
    import naxi_slv_pkg::*;
#(
    parameter int          NXADDRWIDTH = 31,
    parameter int          NXDATAWIDTH = 256,
    parameter int          NXIDWIDTH   = 4,
    parameter int          NXTYPEWIDTH = 3,
    parameter int          NXSIZEWIDTH = 8,
    parameter int          NXATTRWIDTH = 3,
    parameter int          BITMEM      = 10,
    parameter int          CMDDEPTH    = 4,
    parameter int          RDLAT       = 6,
    parameter logic [15:0] LFSRSEED    = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_creq_valid,
    input  logic [NXTYPEWIDTH-1:0] m_creq_type,
    input  logic [NXATTRWIDTH-1:0] m_creq_attr,
    input  logic [NXSIZEWIDTH-1:0] m_creq_size,
    input  logic [NXIDWIDTH-1:0]   m_creq_id,
    input  logic [NXADDRWIDTH-1:0] m_creq_addr,
    output logic                   m_creq_rdstall,
    output logic                   m_creq_wrstall,
    input  logic                   m_dreq_valid,
    input  logic [NXIDWIDTH-1:0]   m_dreq_id,
    input  logic [NXDATAWIDTH-1:0] m_dreq_data,
    input  logic [NXATTRWIDTH-1:0] m_dreq_attr,
    output logic                   m_dreq_stall,
    output logic                   m_rreq_valid,
    output logic [NXIDWIDTH-1:0]   m_rreq_id,
    output logic [NXDATAWIDTH-1:0] m_rreq_data,
    output logic [NXATTRWIDTH-1:0] m_rreq_attr,
    input  logic                   m_rreq_stall,
    output logic                   err
);

    localparam int OFFS = $clog2(NXDATAWIDTH / 8);
    localparam int LATW = $clog2(RDLAT) + 1;

    // Array index of beat n of a burst; wraps silently at the array end.
    function automatic logic [BITMEM-1:0] beat_idx(input logic [BITMEM-1:0] base,
                                                   input logic [NXSIZEWIDTH-1:0] beat);
        return base + BITMEM'(beat);
    endfunction

    logic [NXDATAWIDTH-1:0] mem_q [2**BITMEM];

    nx_cmd_t cmd_in, rd_head, wr_head, rcmd_q, rcmd_d;
    logic    rd_full, rd_empty, wr_full, wr_empty;
    logic    rd_push, wr_push, rd_pop, wr_pop, illegal, dreq_fire, wait_done;

    rd_state_e              state_q, state_d;
    logic [LATW-1:0]        lat_q, lat_d;
    logic [NXSIZEWIDTH-1:0] rbeat_q, rbeat_d, rbeat_nx;
    logic [NXSIZEWIDTH-1:0] wbeat_q, wbeat_d;
    logic                   rvalid_q, rvalid_d, rlast_q, rlast_d, err_q, err_d;
    logic [NXIDWIDTH-1:0]   rid_q, rid_d;
    logic [NXDATAWIDTH-1:0] rdata_q, rdata_d;

    logic unused_bits;
    assign unused_bits = ^{m_creq_attr, m_dreq_attr,
                           m_creq_addr[NXADDRWIDTH-1:BITMEM+OFFS], m_creq_addr[OFFS-1:0]};

    assign cmd_in = '{id: m_creq_id, size: m_creq_size,
                      index: m_creq_addr[BITMEM+OFFS-1:OFFS]};

`ifdef NAXI_SLV_RANDSTALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        extra_q, extra_d;

    // Fibonacci taps 16,14,13,11 (maximal length).
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q  <= LFSRSEED;
            extra_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            extra_q <= extra_d;
        end
    end

    assign m_creq_rdstall = rd_full | lfsr_q[0];
    assign m_creq_wrstall = wr_full | lfsr_q[1];
    assign m_dreq_stall   = wr_empty | lfsr_q[2];
    assign wait_done      = (lat_q == '0) && !extra_q;

    always_comb begin
        extra_d = extra_q;
        if (state_q == IDLE && rd_pop) extra_d = lfsr_q[3];
        else if (state_q == WAIT && lat_q == '0) extra_d = 1'b0;
    end
`else
    assign m_creq_rdstall = rd_full;
    assign m_creq_wrstall = wr_full;
    assign m_dreq_stall   = wr_empty;
    assign wait_done      = (lat_q == '0);
`endif

    assign rd_push = m_creq_valid && (m_creq_type == NXTYPEWIDTH'(NX_TYPE_RD)) && !m_creq_rdstall;
    assign wr_push = m_creq_valid && (m_creq_type == NXTYPEWIDTH'(NX_TYPE_WR)) && !m_creq_wrstall;
    assign illegal = m_creq_valid && (m_creq_type != NXTYPEWIDTH'(NX_TYPE_RD))
                                  && (m_creq_type != NXTYPEWIDTH'(NX_TYPE_WR));

    naxi_slv_fifo #(.WIDTH($bits(nx_cmd_t)), .DEPTH(CMDDEPTH)) u_rd_fifo (
        .clk(clk), .rst(rst), .push_i(rd_push), .push_data_i(cmd_in),
        .pop_i(rd_pop), .head_o(rd_head), .full_o(rd_full), .empty_o(rd_empty)
    );

    naxi_slv_fifo #(.WIDTH($bits(nx_cmd_t)), .DEPTH(CMDDEPTH)) u_wr_fifo (
        .clk(clk), .rst(rst), .push_i(wr_push), .push_data_i(cmd_in),
        .pop_i(wr_pop), .head_o(wr_head), .full_o(wr_full), .empty_o(wr_empty)
    );

    // Write engine: beats of the head write command go straight to the array.
    assign dreq_fire = m_dreq_valid && !m_dreq_stall;
    assign wr_pop    = dreq_fire && (wbeat_q == wr_head.size);

    always_comb begin
        wbeat_d = wbeat_q;
        if (dreq_fire) wbeat_d = wr_pop ? '0 : wbeat_q + NXSIZEWIDTH'(1);
        // A mismatched data id is still written; only the error flag records it.
        err_d = err_q | illegal | (dreq_fire && (m_dreq_id != wr_head.id));
    end

    always_ff @(posedge clk) begin
        if (rst && dreq_fire) mem_q[beat_idx(wr_head.index, wbeat_q)] <= m_dreq_data;
    end

    // Read engine. Output registers are loaded at presentation time and held
    // untouched while the beat is stalled.
    assign rbeat_nx = rbeat_q + NXSIZEWIDTH'(1);

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        rbeat_d  = rbeat_q;
        rcmd_d   = rcmd_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        rd_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rd_empty && wr_empty) begin
                    rd_pop  = 1'b1;
                    rcmd_d  = rd_head;
                    lat_d   = LATW'(RDLAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_d  = BURST;
                    rbeat_d  = '0;
                    rvalid_d = 1'b1;
                    rid_d    = rcmd_q.id;
                    rdata_d  = mem_q[rcmd_q.index];
                    rlast_d  = (rcmd_q.size == '0);
                end else if (lat_q != '0) begin
                    lat_d = lat_q - LATW'(1);
                end
            end
            BURST: begin
                if (!m_rreq_stall) begin
                    if (rlast_q) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        rid_d    = '0;
                        rdata_d  = '0;
                        rlast_d  = 1'b0;
                    end else begin
                        rbeat_d = rbeat_nx;
                        rdata_d = mem_q[beat_idx(rcmd_q.index, rbeat_nx)];
                        rlast_d = (rbeat_nx == rcmd_q.size);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            rbeat_q  <= '0;
            rcmd_q   <= '0;
            wbeat_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            rbeat_q  <= rbeat_d;
            rcmd_q   <= rcmd_d;
            wbeat_q  <= wbeat_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            err_q    <= err_d;
        end
    end

    assign m_rreq_valid = rvalid_q;
    assign m_rreq_id    = rid_q;
    assign m_rreq_data  = rdata_q;
    assign err          = err_q;

    always_comb begin
        m_rreq_attr               = '0;
        m_rreq_attr[NX_ATTR_LAST] = rlast_q;
    end

endmodule

// File: tb/tb_naxi_slave_mem_model.sv
module tb_naxi_slave_mem_model;

    localparam int AW    = 31;
    localparam int DW    = 256;
    localparam int IW    = 4;
    localparam int TW    = 3;
    localparam int SW    = 8;
    localparam int ATW   = 3;
    localparam int BM    = 10;
    localparam int DEPTH = 4;
    localparam int RDLAT = 6;
    localparam int NENT  = 1 << BM;
    localparam int OFFS  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_creq_valid;
    logic [TW-1:0] m_creq_type;
    logic [ATW-1:0] m_creq_attr;
    logic [SW-1:0] m_creq_size;
    logic [IW-1:0] m_creq_id;
    logic [AW-1:0] m_creq_addr;
    logic          m_creq_rdstall, m_creq_wrstall;
    logic          m_dreq_valid;
    logic [IW-1:0] m_dreq_id;
    logic [DW-1:0] m_dreq_data;
    logic [ATW-1:0] m_dreq_attr;
    logic          m_dreq_stall;
    logic          m_rreq_valid;
    logic [IW-1:0] m_rreq_id;
    logic [DW-1:0] m_rreq_data;
    logic [ATW-1:0] m_rreq_attr;
    logic          m_rreq_stall;
    logic          err;

    always #5 clk = ~clk;

    naxi_slave_mem_model #(
        .NXADDRWIDTH(AW), .NXDATAWIDTH(DW), .NXIDWIDTH(IW), .NXTYPEWIDTH(TW),
        .NXSIZEWIDTH(SW), .NXATTRWIDTH(ATW), .BITMEM(BM), .CMDDEPTH(DEPTH),
        .RDLAT(RDLAT), .LFSRSEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst),
        .m_creq_valid(m_creq_valid), .m_creq_type(m_creq_type), .m_creq_attr(m_creq_attr),
        .m_creq_size(m_creq_size), .m_creq_id(m_creq_id), .m_creq_addr(m_creq_addr),
        .m_creq_rdstall(m_creq_rdstall), .m_creq_wrstall(m_creq_wrstall),
        .m_dreq_valid(m_dreq_valid), .m_dreq_id(m_dreq_id), .m_dreq_data(m_dreq_data),
        .m_dreq_attr(m_dreq_attr), .m_dreq_stall(m_dreq_stall),
        .m_rreq_valid(m_rreq_valid), .m_rreq_id(m_rreq_id), .m_rreq_data(m_rreq_data),
        .m_rreq_attr(m_rreq_attr), .m_rreq_stall(m_rreq_stall), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // Reference image of the backing array.
    logic [DW-1:0] mem_m [NENT];
    // Explicit write beats for directed tests; empty means random data.
    logic [DW-1:0] wq [$];

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic int idx_of(input logic [AW-1:0] addr, input int beat);
        return ((int'(addr) >> OFFS) + beat) % NENT;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_creq_valid = 1'b0;
        m_creq_type  = '0;
        m_creq_attr  = '0;
        m_creq_size  = '0;
        m_creq_id    = '0;
        m_creq_addr  = '0;
        m_dreq_valid = 1'b0;
        m_dreq_id    = '0;
        m_dreq_data  = '0;
        m_dreq_attr  = '0;
        m_rreq_stall = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    task automatic send_cmd(input logic [TW-1:0] typ, input logic [AW-1:0] addr,
                            input logic [SW-1:0] size, input logic [IW-1:0] id);
        int n;
        m_creq_valid = 1'b1;
        m_creq_type  = typ;
        m_creq_addr  = addr;
        m_creq_size  = size;
        m_creq_id    = id;
        m_creq_attr  = 3'($urandom_range(0, 7));
        n = 0;
        while (((typ == 0) ? m_creq_rdstall : m_creq_wrstall) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout type=%0d addr=%h", typ, addr);
        end
        tick();
        m_creq_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                               input logic [IW-1:0] cid, input logic [IW-1:0] did);
        logic [DW-1:0] d;
        int n;
        send_cmd(3'd1, addr, size, cid);
        for (int b = 0; b <= int'(size); b++) begin
            d = (wq.size() != 0) ? wq.pop_front() : rand_data();
            m_dreq_valid = 1'b1;
            m_dreq_id    = did;
            m_dreq_data  = d;
            n = 0;
            while (m_dreq_stall && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL dreq_accept_timeout beat=%0d", b);
            end
            tick();
            mem_m[idx_of(addr, b)] = d;
        end
        m_dreq_valid = 1'b0;
    endtask

    // Issues a read, checks first-beat latency, then every presented beat
    // (including held beats under stall) against the reference array.
    task automatic read_check(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                              input logic [IW-1:0] id, input int stall0, input bit rnd);
        int n, b, held, guard;
        logic stall, explast;
        logic [DW-1:0] exp;
        send_cmd(3'd0, addr, size, id);
        n = 0;
        while (!m_rreq_valid && n < RDLAT + 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== RDLAT + 1) begin
            errors++;
            $display("FAIL rd_latency got=%0d cycles want=%0d", n, RDLAT + 1);
        end
        b = 0;
        held = 0;
        guard = 0;
        while (b <= int'(size) && guard < 400) begin
            stall = (b == 0 && held < stall0) || (rnd && $urandom_range(0, 3) == 0);
            if (b == 0 && stall) held++;
            m_rreq_stall = stall;
            exp = mem_m[idx_of(addr, b)];
            explast = (b == int'(size));
            checks++;
            if (m_rreq_valid !== 1'b1 || m_rreq_data !== exp || m_rreq_id !== id ||
                m_rreq_attr !== {2'b00, explast}) begin
                errors++;
                $display("FAIL rd_beat%0d valid=%b id=%0d attr=%0d data=%h want id=%0d attr=%0d data=%h",
                         b, m_rreq_valid, m_rreq_id, m_rreq_attr, m_rreq_data, id, explast, exp);
            end
            if (!stall) b++;
            tick();
            guard++;
        end
        m_rreq_stall = 1'b0;
        checks++;
        if (m_rreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_end_valid got=%b want=0", m_rreq_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (m_rreq_valid !== 1'b0 || m_creq_rdstall !== 1'b0 || m_creq_wrstall !== 1'b0 ||
            m_dreq_stall !== 1'b1 || err !== 1'b0 || m_rreq_id !== '0 ||
            m_rreq_data !== '0 || m_rreq_attr !== '0) begin
            errors++;
            $display("FAIL %s vld=%b rdst=%b wrst=%b dst=%b err=%b id=%0d attr=%0d want 0,0,0,1,0,0,0",
                     tag, m_rreq_valid, m_creq_rdstall, m_creq_wrstall, m_dreq_stall, err,
                     m_rreq_id, m_rreq_attr);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        apply_reset(3);
        check_reset_outputs("reset_state");
    endtask

    task automatic test_write_read();
        wq.push_back({8{32'hAAAA_0001}});
        wq.push_back({8{32'hBBBB_0002}});
        write_burst(31'h40, 8'd1, 4'd3, 4'd3);
        read_check(31'h40, 8'd1, 4'd5, 0, 1'b0);
    endtask

    task automatic test_read_stall();
        read_check(31'h40, 8'd1, 4'd5, 4, 1'b0);
    endtask

    task automatic test_rd_fifo_full();
        m_rreq_stall = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            m_creq_valid = 1'b1;
            m_creq_type  = 3'd0;
            m_creq_size  = 8'd0;
            m_creq_id    = 4'(k);
            m_creq_addr  = 31'(k * 32);
            checks++;
            if (m_creq_rdstall !== (k == DEPTH + 1)) begin
                errors++;
                $display("FAIL fifo_full_rdstall read=%0d got=%b want=%b", k, m_creq_rdstall, k == DEPTH + 1);
            end
            checks++;
            if (m_creq_wrstall !== 1'b0) begin
                errors++;
                $display("FAIL fifo_full_wrstall read=%0d got=%b want=0", k, m_creq_wrstall);
            end
            tick();
        end
        m_creq_valid = 1'b0;
        repeat (RDLAT + 3) tick();
        checks++;
        if (m_rreq_valid !== 1'b1 || m_rreq_id !== 4'd0 || m_creq_rdstall !== 1'b1) begin
            errors++;
            $display("FAIL stalled_burst valid=%b id=%0d rdstall=%b want 1,0,1", m_rreq_valid, m_rreq_id, m_creq_rdstall);
        end
        // Reset mid-burst: burst abandoned, queued reads discarded.
        apply_reset(1);
        check_reset_outputs("reset_mid_burst");
        m_rreq_stall = 1'b0;
        repeat (RDLAT + 4) tick();
        checks++;
        if (m_rreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle valid=%b want 0", m_rreq_valid);
        end
    endtask

    task automatic test_wrap();
        wq.push_back({8{32'h1234_5678}});
        write_burst(31'h4000_7FE0, 8'd0, 4'd1, 4'd1);
        wq.push_back({8{32'h9ABC_DEF0}});
        write_burst(31'h0, 8'd0, 4'd1, 4'd1);
        read_check(31'h7FE0, 8'd1, 4'd9, 0, 1'b0);
        // A write burst that itself wraps, read back with random stalls.
        write_burst(31'h7FC0, 8'd3, 4'd4, 4'd4);
        read_check(31'h7FC0, 8'd3, 4'd6, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [SW-1:0] ws, rs;
        logic [IW-1:0] id;
        for (int t = 0; t < 16; t++) begin
            a  = AW'($urandom());
            ws = SW'($urandom_range(0, 7));
            rs = SW'($urandom_range(0, int'(ws)));
            id = IW'($urandom());
            write_burst(a, ws, id, id);
            read_check(a, rs, IW'($urandom()), $urandom_range(0, 2), 1'b1);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL random_err got=%b want=0", err);
        end
    endtask

    task automatic test_back_to_back();
        write_burst(31'h100, 8'd1, 4'd2, 4'd2);
        write_burst(31'h200, 8'd2, 4'd2, 4'd2);
        read_check(31'h100, 8'd1, 4'd1, 0, 1'b0);
        read_check(31'h200, 8'd2, 4'd2, 0, 1'b1);
    endtask

    task automatic test_id_mismatch();
        wq.push_back({8{32'hC0DE_0007}});
        write_burst(31'h300, 8'd0, 4'd2, 4'd7);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL id_mismatch_err got=%b want=1", err);
        end
        read_check(31'h300, 8'd0, 4'd3, 0, 1'b0);
        repeat (5) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
        apply_reset(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got=%b want=0", err);
        end
        // Illegal command type: dropped and flagged.
        m_creq_valid = 1'b1;
        m_creq_type  = 3'd3;
        m_creq_addr  = 31'h40;
        tick();
        m_creq_valid = 1'b0;
        repeat (RDLAT + 3) tick();
        checks++;
        if (err !== 1'b1 || m_dreq_stall !== 1'b1 || m_rreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_type err=%b dstall=%b valid=%b want 1,1,0", err, m_dreq_stall, m_rreq_valid);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_read_stall();
        test_rd_fifo_full();
        test_wrap();
        test_back_to_back();
        test_random();
        test_id_mismatch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
